// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core with a unified instruction/data memory.
// Sequences fetch/decode/address/memory/execute/writeback steps, stalls memory steps
// on mem_ready and pulses InstrDone once per retired instruction.
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to trap unknown opcodes in a sticky
// TRAP state that raises Illegal; otherwise unknown opcodes retire as NOPs.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    StTrap
`endif
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;

  state_e state_q, state_d;
  logic   pc_update;
  logic   branch;
  logic   taken;

  // Subtraction is only selected for R-type (op[5] set) with funct7b5; I-type never subtracts.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] ctl;
    ctl = AluAdd;
    case (f3)
      3'b000:  ctl = sub_sel ? AluSub : AluAdd;
      3'b010:  ctl = AluSlt;
      3'b110:  ctl = AluOr;
      3'b111:  ctl = AluAnd;
      default: ctl = AluAdd;
    endcase
    return ctl;
  endfunction

  // State register; reset always returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Branch condition: only beq/bne are resolved, everything else falls through.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and Moore/Mealy outputs; every output defaults to 0 and is forced to 0 in reset.
  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = AluAdd;
    ImmSrc     = ImmI;
    RegWrite   = 1'b0;
    InstrDone  = 1'b0;
    Illegal    = 1'b0;

    case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          pc_update = 1'b1;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            state_d = StTrap;
`else
            // Unknown opcode retires here as a NOP.
            InstrDone = 1'b1;
            state_d   = StFetch;
`endif
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? ImmS : ImmI;
        state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        // Strobe held for the whole wait, including the completing cycle.
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          InstrDone = 1'b1;
          state_d   = StFetch;
        end
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, op[5] & funct7b5);
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, op[5] & funct7b5);
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        ImmSrc     = ImmB;
        branch     = 1'b1;
        InstrDone  = 1'b1;
        state_d    = StFetch;
      end
      StJal: begin
        // Link value PC+4 goes through ALUWB; retire is signalled there.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ImmSrc    = ImmJ;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      StTrap: begin
        Illegal = 1'b1;
        state_d = StTrap;
      end
`endif
      default: state_d = StFetch;
    endcase

    PCWrite = pc_update | (branch & taken);

    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = AluAdd;
      ImmSrc     = ImmI;
      RegWrite   = 1'b0;
      InstrDone  = 1'b0;
      Illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed per-cycle vector table, hand sequences
// for stalls/reset/unknown opcodes, and a randomized instruction stream checked against a
// phase-based latency/event-count model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  // Bit 18..0: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc
  //            RegWrite InstrDone Illegal
  logic [18:0] ov;
  assign ov = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
               ImmSrc, RegWrite, InstrDone, Illegal};

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] UK = 7'b1111111;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic [2:0] imm,
                                     input logic rw, input logic dn, input logic il);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, il};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, sample outputs mid-cycle, advance past the rising edge.
  task automatic cyc(input logic mr, output logic [18:0] o);
    mem_ready = mr;
    @(negedge clk);
    o = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o_, input logic [2:0] f3, input logic f7,
                           input logic z);
    op = o_;
    funct3 = f3;
    funct7b5 = f7;
    Zero = z;
  endtask

  task automatic do_reset(input int n);
    logic [18:0] o;
    reset = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b1, o);
    reset = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    int          cycle;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic [18:0] fetch_v, decode_v;

  initial begin
    logic [18:0] o;
    logic [6:0]  mw_pat, dn_pat;

    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] o;
    logic [6:0]  mw_pat, dn_pat;
    logic        mr;

    fetch_v  = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0, 0);
    decode_v = mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0, 0, 0);

    vecs.push_back('{"lw_fetch", LW, 3'd2, 0, 0, 1, fetch_v});
    vecs.push_back('{"lw_decode", LW, 3'd2, 0, 0, 2, decode_v});
    vecs.push_back('{"lw_memadr", LW, 3'd2, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0,0)});
    vecs.push_back('{"lw_memread", LW, 3'd2, 0, 0, 4, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,0)});
    vecs.push_back('{"lw_memwb", LW, 3'd2, 0, 0, 5, mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,3'b000,1,1,0)});
    vecs.push_back('{"lw_next_fetch", LW, 3'd2, 0, 0, 6, fetch_v});
    vecs.push_back('{"sw_memadr", SW, 3'd2, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0,0,0)});
    vecs.push_back('{"sw_memwrite", SW, 3'd2, 0, 0, 4, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,1,0)});
    vecs.push_back('{"sub_execr", RT, 3'd0, 1, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,0,0)});
    vecs.push_back('{"sub_aluwb", RT, 3'd0, 1, 0, 4, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,1,0)});
    vecs.push_back('{"add_execr", RT, 3'd0, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000,0,0,0)});
    vecs.push_back('{"slt_execr", RT, 3'd2, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b101,3'b000,0,0,0)});
    vecs.push_back('{"or_execr", RT, 3'd6, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b011,3'b000,0,0,0)});
    vecs.push_back('{"and_execr", RT, 3'd7, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b010,3'b000,0,0,0)});
    vecs.push_back('{"xor_execr", RT, 3'd4, 1, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000,0,0,0)});
    vecs.push_back('{"addi_f7_execi", IT, 3'd0, 1, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0,0,0)});
    vecs.push_back('{"slti_execi", IT, 3'd2, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b101,3'b000,0,0,0)});
    vecs.push_back('{"addi_aluwb", IT, 3'd0, 0, 0, 4, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,1,0)});
    vecs.push_back('{"beq_z1", BR, 3'd0, 0, 1, 3, mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,1,0)});
    vecs.push_back('{"bne_z1", BR, 3'd1, 0, 1, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,1,0)});
    vecs.push_back('{"bne_z0", BR, 3'd1, 0, 0, 3, mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,1,0)});
    vecs.push_back('{"beq_z0", BR, 3'd0, 0, 0, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,1,0)});
    vecs.push_back('{"blt_z1", BR, 3'd4, 0, 1, 3, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0,1,0)});
    vecs.push_back('{"beq_next_fetch", BR, 3'd0, 0, 1, 4, fetch_v});
    vecs.push_back('{"jal_jal", JL, 3'd0, 0, 0, 3, mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b011,0,0,0)});
    vecs.push_back('{"jal_aluwb", JL, 3'd0, 0, 0, 4, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1,1,0)});
`ifdef MULTICYCLE_CTRL_TRAP_EN
    vecs.push_back('{"unk_decode", UK, 3'd0, 0, 0, 2, decode_v});
    vecs.push_back('{"unk_trap", UK, 3'd0, 0, 0, 3, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,1)});
`else
    vecs.push_back('{"unk_decode", UK, 3'd0, 0, 0, 2, decode_v | 19'h2});
    vecs.push_back('{"unk_next_fetch", UK, 3'd0, 0, 0, 3, fetch_v});
`endif

    // Reset: two cycles with mem_ready high show all-zero outputs, then FETCH.
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1'b1, o);
    chk("reset_cycle1", o, 19'd0);
    cyc(1'b1, o);
    chk("reset_cycle2", o, 19'd0);
    reset = 1'b0;
    cyc(1'b1, o);
    chk("post_reset_fetch", o, fetch_v);

    // Table of per-cycle vectors with mem_ready tied high, each from a fresh reset.
    foreach (vecs[i]) begin
      do_reset(1);
      set_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      for (int k = 1; k <= vecs[i].cycle; k++) begin
        cyc(1'b1, o);
        if (k == vecs[i].cycle) chk(vecs[i].name, o, vecs[i].exp);
      end
    end

    // FETCH stall: no IRWrite/PCWrite until mem_ready.
    do_reset(1);
    set_instr(RT, 3'd0, 0, 0);
    cyc(1'b0, o);
    chk("fetch_stall", o, mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0,0,0));
    cyc(1'b1, o);
    chk("fetch_after_stall", o, fetch_v);

    // sw with three wait cycles: MemWrite for four cycles, retire on the fourth, 7 total.
    do_reset(1);
    set_instr(SW, 3'd2, 0, 0);
    mw_pat = '0;
    dn_pat = '0;
    for (int k = 0; k < 7; k++) begin
      cyc((k < 3 || k == 6) ? 1'b1 : 1'b0, o);
      mw_pat = {mw_pat[5:0], o[16]};
      dn_pat = {dn_pat[5:0], o[1]};
    end
    chk("sw_wait_memwrite", {25'd0, mw_pat}, 32'h0F);
    chk("sw_wait_done", {25'd0, dn_pat}, 32'h01);
    cyc(1'b1, o);
    chk("sw_wait_next_fetch", o, fetch_v);

    // Reset during a MEMWRITE wait aborts with no InstrDone.
    do_reset(1);
    set_instr(SW, 3'd2, 0, 0);
    dn_pat = '0;
    for (int k = 0; k < 5; k++) begin
      cyc((k < 3) ? 1'b1 : 1'b0, o);
      dn_pat = {dn_pat[5:0], o[1]};
    end
    chk("abort_memwrite_before", {25'd0, dn_pat}, 32'h0);
    chk("abort_memwrite_strobe", {31'd0, o[16]}, 32'h1);
    reset = 1'b1;
    cyc(1'b1, o);
    chk("abort_reset_outputs", o, 19'd0);
    reset = 1'b0;
    cyc(1'b1, o);
    chk("abort_then_fetch", o, fetch_v);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    // Trap holds Illegal through mem_ready activity until reset.
    do_reset(1);
    set_instr(UK, 3'd0, 0, 0);
    cyc(1'b1, o);
    cyc(1'b1, o);
    for (int k = 0; k < 4; k++) begin
      cyc(k[0], o);
      chk("trap_hold", o, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0,1));
    end
    reset = 1'b1;
    cyc(1'b1, o);
    chk("trap_reset_outputs", o, 19'd0);
    reset = 1'b0;
    set_instr(RT, 3'd0, 0, 0);
    cyc(1'b1, o);
    chk("trap_then_fetch", o, fetch_v);
`endif

    // Randomized stream: each instruction is a list of phases, fixed (1 cycle) or memory
    // (waits until mem_ready); counts of events follow from the instruction class.
    do_reset(1);
    for (int n = 0; n < 80; n++) begin
      int          kind, fixed_after[$], memw_len, rw_cnt, mw_cnt, pw_cnt, iw_cnt, dn_cnt;
      int          exp_rw, exp_mw, exp_pw;
      logic        last_dn, tk, is_mem;
      logic [2:0]  f3;
      logic        z, f7;
      int          nph;
      logic [6:0]  opc;
      int          phases[$];

      kind = $urandom_range(0, 6);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      if (kind == 6) kind = 2;
`endif
      f3 = (kind == 4) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      tk = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
      case (kind)
        0: begin opc = LW; phases = '{1, 0, 0, 1, 0}; exp_rw = 1; exp_pw = 1; end
        1: begin opc = SW; phases = '{1, 0, 0, 1};    exp_rw = 0; exp_pw = 1; end
        2: begin opc = RT; phases = '{1, 0, 0, 0};    exp_rw = 1; exp_pw = 1; end
        3: begin opc = IT; phases = '{1, 0, 0, 0};    exp_rw = 1; exp_pw = 1; end
        4: begin opc = BR; phases = '{1, 0, 0};       exp_rw = 0; exp_pw = tk ? 2 : 1; end
        5: begin opc = JL; phases = '{1, 0, 0, 0};    exp_rw = 1; exp_pw = 2; end
        default: begin
          opc = ($urandom_range(0, 1) == 0) ? UK : 7'b0110111;
          phases = '{1, 0}; exp_rw = 0; exp_pw = 1;
        end
      endcase
      set_instr(opc, f3, f7, z);
      rw_cnt = 0; mw_cnt = 0; pw_cnt = 0; iw_cnt = 0; dn_cnt = 0; memw_len = 0;
      last_dn = 1'b0;
      nph = phases.size();
      for (int p = 0; p < nph; p++) begin
        is_mem = (phases[p] == 1);
        if (is_mem) memw_len = 0;
        for (int w = 0; w < 8; w++) begin
          mr = (is_mem && w >= 3) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
          cyc(mr, o);
          rw_cnt += int'(o[2]);
          mw_cnt += int'(o[16]);
          pw_cnt += int'(o[18]);
          iw_cnt += int'(o[15]);
          dn_cnt += int'(o[1]);
          last_dn = o[1];
          memw_len++;
          if (!is_mem || mr) break;
        end
      end
      exp_mw = (kind == 1) ? memw_len : 0;
      chk("rand_retire_once_last", {30'd0, last_dn, 1'b0} | 32'(dn_cnt), 32'h3);
      chk("rand_regwrite", 32'(rw_cnt), 32'(exp_rw));
      chk("rand_memwrite", 32'(mw_cnt), 32'(exp_mw));
      chk("rand_pcwrite", 32'(pw_cnt), 32'(exp_pw));
      chk("rand_irwrite", 32'(iw_cnt), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
